// File: rtl/if_prefetch.sv
`default_nettype none
// =============================================================================
// Module   : if_prefetch
// Purpose  : Instruction-fetch stage with a DEPTH-entry prefetch queue; absorbs
//            cache misses and flushes on ID redirects (also during a miss).
// Revision : 1.0
// =============================================================================
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_i,
    output logic                       re_CACHE_o,
    output logic [XLEN-1:0]            addr_CACHE_o,
    input  logic [XLEN-1:0]            data_CACHE_i,
    input  logic                       miss_CACHE_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_addr_i,
    output logic                       valid_o,
    output logic [XLEN-1:0]            inst_o,
    output logic [XLEN-1:0]            pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic              r_started;
    logic              r_miss_hold;
    logic              r_redir_pend;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_pend_addr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_count;
    logic [XLEN-1:0]   r_pc_mem   [DEPTH];
    logic [XLEN-1:0]   r_inst_mem [DEPTH];

    logic              w_full;
    logic              w_miss;
    logic              w_hit;
    logic              w_push;
    logic              w_pop;
    logic [XLEN-1:0]   w_target;

    // Fullness uses registered count only, so a same-cycle pop never enables a fetch.
    assign w_full     = (r_count == c_CW'(DEPTH));
    assign re_CACHE_o = r_started && (!w_full || r_miss_hold);
    assign w_miss     = re_CACHE_o && miss_CACHE_i;
    assign w_hit      = re_CACHE_o && !miss_CACHE_i;
    assign w_push     = w_hit && !redirect_i && !r_redir_pend;
    assign w_pop      = valid_o && !stall_i;
    assign w_target   = {redirect_addr_i[XLEN-1:2], 2'b00};

    assign addr_CACHE_o = r_fetch_pc;
    assign valid_o      = (r_count != '0);
    assign inst_o       = valid_o ? r_inst_mem[r_rd_ptr] : '0;
    assign pc_o         = valid_o ? r_pc_mem[r_rd_ptr]   : '0;
    assign count_o      = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started    <= 1'b0;
            r_miss_hold  <= 1'b0;
            r_redir_pend <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_pend_addr  <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_started   <= 1'b1;
            r_miss_hold <= w_miss;
            if (redirect_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                // During a miss the cache needs a stable address; park the target.
                if (w_miss) begin
                    r_pend_addr  <= w_target;
                    r_redir_pend <= 1'b1;
                end else begin
                    r_fetch_pc   <= w_target;
                    r_redir_pend <= 1'b0;
                end
            end else begin
                if (w_hit) begin
                    if (r_redir_pend) begin
                        r_fetch_pc   <= r_pend_addr;
                        r_redir_pend <= 1'b0;
                    end else begin
                        r_fetch_pc   <= r_fetch_pc + XLEN'(4);
                    end
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= data_CACHE_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// =============================================================================
// Module   : tb_if_prefetch
// Purpose  : Self-checking bench for if_prefetch: directed table, corner-case
//            sequences and random traffic against a queue-based reference.
// Revision : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_if_prefetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        miss_CACHE_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic [31:0] data_CACHE_i;
    logic        re_CACHE_o;
    logic [31:0] addr_CACHE_o;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .re_CACHE_o      (re_CACHE_o),
        .addr_CACHE_o    (addr_CACHE_o),
        .data_CACHE_i    (data_CACHE_i),
        .miss_CACHE_i    (miss_CACHE_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .valid_o         (valid_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .count_o         (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Garbage on a miss so a wrongly-pushed word is visible.
    assign data_CACHE_i = miss_CACHE_i ? 32'hDEAD_BEEF : mem_word(addr_CACHE_o);

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_fpc;
    logic        m_started;
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        m_inmiss;

    function automatic logic m_re();
        return m_started && ((m_q.size() < DEPTH) || m_inmiss);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fpc     = RESET_PC;
        m_started = 1'b0;
        m_pend    = 1'b0;
        m_paddr   = '0;
        m_inmiss  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (m_q.size() > 0) ? m_q[0].pc   : 32'h0;
        e_inst = (m_q.size() > 0) ? m_q[0].inst : 32'h0;
        chk("model.re",    32'(re_CACHE_o), 32'(m_re()));
        chk("model.addr",  addr_CACHE_o,    m_fpc);
        chk("model.valid", 32'(valid_o),    32'(m_q.size() > 0));
        chk("model.pc",    pc_o,            e_pc);
        chk("model.inst",  inst_o,          e_inst);
        chk("model.count", 32'(count_o),    32'(m_q.size()));
    endtask

    task automatic model_update(input logic st, input logic mi, input logic rd, input logic [31:0] ra);
        logic re;
        re = m_re();
        if (rd) begin
            m_q.delete();
            if (re && mi) begin
                m_pend  = 1'b1;
                m_paddr = ra & 32'hFFFF_FFFC;
            end else begin
                m_fpc  = ra & 32'hFFFF_FFFC;
                m_pend = 1'b0;
            end
        end else begin
            if (m_q.size() > 0 && !st) void'(m_q.pop_front());
            if (re && !mi) begin
                if (m_pend) begin
                    m_fpc  = m_paddr;
                    m_pend = 1'b0;
                end else begin
                    m_q.push_back('{pc: m_fpc, inst: mem_word(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
        m_inmiss  = re && mi;
        m_started = 1'b1;
    endtask

    // Called at posedge+1: drive, compare against model, advance one clock.
    task automatic cycle(input logic st, input logic mi, input logic rd, input logic [31:0] ra);
        stall_i         = st;
        miss_CACHE_i    = mi;
        redirect_i      = rd;
        redirect_addr_i = ra;
        model_check();
        model_update(st, mi, rd, ra);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".re"},    32'(re_CACHE_o), 32'h0);
        chk({nm, ".addr"},  addr_CACHE_o,    RESET_PC);
        chk({nm, ".valid"}, 32'(valid_o),    32'h0);
        chk({nm, ".inst"},  inst_o,          32'h0);
        chk({nm, ".pc"},    pc_o,            32'h0);
        chk({nm, ".count"}, 32'(count_o),    32'h0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        miss_CACHE_i    = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic run_until(input logic [31:0] a);
        for (int i = 0; i < 300; i++) begin
            if (addr_CACHE_o == a) break;
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("reach.addr", addr_CACHE_o, a);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rs;
        logic        st;
        logic        e_re;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic st, input logic e_re,
                                input logic [31:0] e_addr, input logic e_v,
                                input logic [31:0] e_pc, input logic [2:0] e_cnt);
        vec_t v;
        v.rs = rs; v.st = st; v.e_re = e_re; v.e_addr = e_addr;
        v.e_v = e_v; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stall from reset: fill to DEPTH, then drain in order while fetching resumes.
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 3'd1);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd2);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00, 3'd3);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04, 3'd3);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08, 3'd3);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd3);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd3);
        // No stall: one instruction per cycle, head pc 0 two cycles after release.
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 3'd1);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 3'd1);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 3'd1);

        #1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rs) do_reset();
            chk($sformatf("tbl%0d.re", i),    32'(re_CACHE_o), 32'(tbl[i].e_re));
            chk($sformatf("tbl%0d.addr", i),  addr_CACHE_o,    tbl[i].e_addr);
            chk($sformatf("tbl%0d.valid", i), 32'(valid_o),    32'(tbl[i].e_v));
            chk($sformatf("tbl%0d.pc", i),    pc_o,            tbl[i].e_pc);
            chk($sformatf("tbl%0d.inst", i),  inst_o,          tbl[i].e_v ? mem_word(tbl[i].e_pc) : 32'h0);
            chk($sformatf("tbl%0d.count", i), 32'(count_o),    32'(tbl[i].e_cnt));
            cycle(tbl[i].st, 1'b0, 1'b0, 32'h0);
        end

        // Miss at 0x20 for three cycles: address held, nothing pushed.
        do_reset();
        run_until(32'h20);
        for (int k = 0; k < 3; k++) begin
            chk("miss.addr", addr_CACHE_o, 32'h20);
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("miss.nopush", 32'(count_o), 32'h0);
        chk("miss.hold_re", 32'(re_CACHE_o), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("miss.pc20", pc_o, 32'h20);
        chk("miss.addr24", addr_CACHE_o, 32'h24);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("miss.pc24", pc_o, 32'h24);

        // Redirect on a hit at 0x40 with two queued entries, while stalled.
        do_reset();
        run_until(32'h3C);
        chk("redir.cnt1", 32'(count_o), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir.addr40", addr_CACHE_o, 32'h40);
        chk("redir.cnt2", 32'(count_o), 32'h2);
        cycle(1'b1, 1'b0, 1'b1, 32'h103);
        chk("redir.flush", 32'(count_o), 32'h0);
        chk("redir.valid0", 32'(valid_o), 32'h0);
        chk("redir.addr100", addr_CACHE_o, 32'h100);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir.pc100", pc_o, 32'h100);
        chk("redir.valid1", 32'(valid_o), 32'h1);

        // Two redirects during one miss: newest wins, missed word dropped.
        do_reset();
        run_until(32'h80);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        chk("pend.addr80a", addr_CACHE_o, 32'h80);
        cycle(1'b0, 1'b1, 1'b1, 32'h300);
        chk("pend.addr80b", addr_CACHE_o, 32'h80);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pend.addr300", addr_CACHE_o, 32'h300);
        chk("pend.drop", 32'(count_o), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pend.pc300", pc_o, 32'h300);
        chk("pend.addr304", addr_CACHE_o, 32'h304);

        // Asynchronous reset in the middle of a miss with a loaded queue.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("arst.cnt3", 32'(count_o), 32'h3);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        miss_CACHE_i = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst.restart_re", 32'(re_CACHE_o), 32'h1);
        chk("arst.restart_addr", addr_CACHE_o, RESET_PC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 5, $urandom);
        end
        model_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
